// File: rtl/sqrt_share_ctrl.sv
// rtl/sqrt_share_ctrl.sv - round-robin sequencer sharing one combinational square-root unit between two requesters
module sqrt_share_ctrl #(
  parameter int E_W = 31,
  parameter int F_W = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [E_W-1:0] req0_e,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [E_W-1:0] req1_e,
  output logic           req1_ready,
  output logic [E_W-1:0] sq_e,
  input  logic [F_W-1:0] sq_f,
  output logic           rsp0_valid,
  output logic [F_W-1:0] rsp0_f,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  output logic [F_W-1:0] rsp1_f,
  input  logic           rsp1_ready,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [E_W-1:0] op_q, op_d;
  logic           tag_q, tag_d;
  logic           zero_q, zero_d;
  logic [F_W-1:0] res_q, res_d;

  logic           grant_valid;
  logic           grant;
  logic [E_W-1:0] grant_e;

  // Round-robin pick: a lone requester wins; on a tie the one not served last time wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    grant_e = grant ? req1_e : req0_e;
  end

  // Next-state and output decode for the IDLE -> ISSUE -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    tag_d        = tag_q;
    zero_d       = zero_q;
    res_d        = res_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = grant_valid & ~grant;
        req1_ready = grant_valid & grant;
        if (grant_valid) begin
          // op_q doubles as the shared unit's operand register, so it only
          // moves here and the unit input stays quiet between transactions.
          op_d         = grant_e;
          tag_d        = grant;
          zero_d       = (grant_e == '0);
          last_grant_d = grant;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // The unit's leading-zero path is undefined for e=0, so force the result.
        res_d   = zero_q ? '0 : sq_f;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~tag_q;
        rsp1_valid = tag_q;
        if (tag_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves requester 0 ahead on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      tag_q        <= 1'b0;
      zero_q       <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      zero_q       <= zero_d;
      res_q        <= res_d;
    end
  end

  assign sq_e   = op_q;
  assign rsp0_f = res_q;
  assign rsp1_f = res_q;
  assign busy   = (state_q != IDLE);

endmodule
